// File: rtl/phase_loop_filter.sv
// phase_loop_filter
//   Proportional-integral loop filter that turns a signed phase error into a
//   corrected frequency control word. Two pipeline stages:
//     stage A (edge of the PHASE_VALID strobe): register the error and update
//       the clamped integrator;
//     stage B (next enabled edge): FREQ_BASE + (err<<KP_SHIFT) + integ,
//       clamped to the unsigned FREQ_BITS range.
//   An optional lock detector watches |err| against LOCK_THRESHOLD.
//
// Ports
//   CLK          rising-edge clock
//   RESET_N      asynchronous active-low reset
//   CE           clock enable (FREQ_VALID still self-clears when CE=0)
//   PHASE_IN     signed phase error, POSITION_BITS wide, 4 fractional bits
//   PHASE_VALID  one-cycle strobe for PHASE_IN
//   FREQ_BASE    nominal frequency word
//   CLEAR        synchronous clear of integrator, lock FSM and pending sample
//   FREQ_OUT     corrected frequency word
//   FREQ_VALID   one-cycle strobe for FREQ_OUT
//   LOCKED       loop-lock indication
//   SATURATED    integrator or output clamp active for the current sample
//
// Build option
//   PHASE_LOOP_FILTER_LOCK_DETECT_EN  include the lock FSM; otherwise LOCKED=0.

module phase_loop_filter #(
    parameter int POSITION_BITS  = 14,
    parameter int FREQ_BITS      = 32,
    parameter int KP_SHIFT       = 4,
    parameter int KI_SHIFT       = 2,
    parameter int INT_LIMIT      = 2**24,
    parameter int LOCK_THRESHOLD = 8,
    parameter int LOCK_COUNT     = 64,
    parameter int LOSS_COUNT     = 4
) (
    input  logic                            CLK,
    input  logic                            RESET_N,
    input  logic                            CE,
    input  logic signed [POSITION_BITS-1:0] PHASE_IN,
    input  logic                            PHASE_VALID,
    input  logic        [FREQ_BITS-1:0]     FREQ_BASE,
    input  logic                            CLEAR,
    output logic        [FREQ_BITS-1:0]     FREQ_OUT,
    output logic                            FREQ_VALID,
    output logic                            LOCKED,
    output logic                            SATURATED
);

    localparam int ACC_BITS = FREQ_BITS + 2;
    typedef logic signed [ACC_BITS-1:0] acc_t;

    localparam acc_t INT_MAX = acc_t'(INT_LIMIT);
    localparam acc_t INT_MIN = -acc_t'(INT_LIMIT);
    localparam acc_t OUT_MAX = acc_t'({2'b00, {FREQ_BITS{1'b1}}});

    logic signed [POSITION_BITS-1:0] err_q;
    acc_t                            integ_q;
    logic                            integ_sat_q;
    logic                            pend_q;

    acc_t                 err_ext;
    acc_t                 integ_sum;
    acc_t                 integ_next;
    acc_t                 out_sum;
    logic                 integ_clamp;
    logic                 out_clamp;
    logic [FREQ_BITS-1:0] freq_next;

    always_comb begin
        err_ext     = acc_t'(PHASE_IN);
        integ_sum   = integ_q + (err_ext <<< KI_SHIFT);
        integ_next  = integ_sum;
        integ_clamp = 1'b0;
        if (integ_sum > INT_MAX) begin
            integ_next  = INT_MAX;
            integ_clamp = 1'b1;
        end else if (integ_sum < INT_MIN) begin
            integ_next  = INT_MIN;
            integ_clamp = 1'b1;
        end

        // Stage B reads the registered error and the integrator already
        // updated by the same sample at stage A.
        out_sum   = acc_t'({2'b00, FREQ_BASE}) + (acc_t'(err_q) <<< KP_SHIFT) + integ_q;
        freq_next = out_sum[FREQ_BITS-1:0];
        out_clamp = 1'b0;
        if (out_sum[ACC_BITS-1]) begin
            freq_next = '0;
            out_clamp = 1'b1;
        end else if (out_sum > OUT_MAX) begin
            freq_next = '1;
            out_clamp = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            err_q       <= '0;
            integ_q     <= '0;
            integ_sat_q <= 1'b0;
            pend_q      <= 1'b0;
            FREQ_OUT    <= '0;
            FREQ_VALID  <= 1'b0;
            SATURATED   <= 1'b0;
        end else begin
            FREQ_VALID <= 1'b0;
            if (CE) begin
                if (CLEAR) begin
                    integ_q <= '0;
                    pend_q  <= 1'b0;
                end else begin
                    if (pend_q) begin
                        FREQ_OUT   <= freq_next;
                        FREQ_VALID <= 1'b1;
                        SATURATED  <= integ_sat_q | out_clamp;
                    end
                    pend_q <= PHASE_VALID;
                    if (PHASE_VALID) begin
                        err_q       <= PHASE_IN;
                        integ_q     <= integ_next;
                        integ_sat_q <= integ_clamp;
                    end
                end
            end
        end
    end

`ifdef PHASE_LOOP_FILTER_LOCK_DETECT_EN
    typedef enum logic [1:0] {ST_UNLOCKED, ST_ACQUIRE, ST_LOCKED} lock_state_t;

    localparam int GOOD_BITS = $clog2(LOCK_COUNT + 1);
    localparam int BAD_BITS  = $clog2(LOSS_COUNT + 1);
    localparam logic [GOOD_BITS-1:0]     GOOD_TARGET = GOOD_BITS'(LOCK_COUNT);
    localparam logic [BAD_BITS-1:0]      BAD_TARGET  = BAD_BITS'(LOSS_COUNT);
    localparam logic [POSITION_BITS-1:0] THRESH      = POSITION_BITS'(LOCK_THRESHOLD);

    lock_state_t            state_q;
    logic [GOOD_BITS-1:0]   good_cnt;
    logic [BAD_BITS-1:0]    bad_cnt;
    logic [POSITION_BITS-1:0] mag;
    logic                   is_min;
    logic                   in_thr;

    // The most negative code has no positive magnitude, so it is excluded
    // explicitly rather than relying on the wrapped negation.
    always_comb begin
        is_min = PHASE_IN[POSITION_BITS-1] && (PHASE_IN[POSITION_BITS-2:0] == '0);
        mag    = PHASE_IN[POSITION_BITS-1] ? $unsigned(-PHASE_IN) : $unsigned(PHASE_IN);
        in_thr = !is_min && (mag <= THRESH);
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q  <= ST_UNLOCKED;
            good_cnt <= '0;
            bad_cnt  <= '0;
            LOCKED   <= 1'b0;
        end else if (CE) begin
            if (CLEAR) begin
                state_q  <= ST_UNLOCKED;
                good_cnt <= '0;
                bad_cnt  <= '0;
                LOCKED   <= 1'b0;
            end else if (PHASE_VALID) begin
                unique case (state_q)
                    ST_UNLOCKED: begin
                        if (in_thr) begin
                            state_q  <= ST_ACQUIRE;
                            good_cnt <= GOOD_BITS'(1);
                        end
                    end
                    ST_ACQUIRE: begin
                        if (!in_thr) begin
                            state_q  <= ST_UNLOCKED;
                            good_cnt <= '0;
                        end else if (good_cnt + 1'b1 == GOOD_TARGET) begin
                            state_q  <= ST_LOCKED;
                            good_cnt <= '0;
                            bad_cnt  <= '0;
                            LOCKED   <= 1'b1;
                        end else begin
                            good_cnt <= good_cnt + 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        if (in_thr) begin
                            bad_cnt <= '0;
                        end else if (bad_cnt + 1'b1 == BAD_TARGET) begin
                            state_q <= ST_UNLOCKED;
                            bad_cnt <= '0;
                            LOCKED  <= 1'b0;
                        end else begin
                            bad_cnt <= bad_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_UNLOCKED;
                        LOCKED  <= 1'b0;
                    end
                endcase
            end
        end
    end
`else
    logic unused_lock_cfg;
    assign unused_lock_cfg = (LOCK_THRESHOLD + LOCK_COUNT + LOSS_COUNT) != 0;
    assign LOCKED = 1'b0;
`endif

endmodule

// File: tb/tb_phase_loop_filter.sv
// tb_phase_loop_filter
//   Directed bench for phase_loop_filter at default parameters. Inputs are
//   driven on the falling edge; outputs are sampled on the falling edge.
//   Lock expectations collapse to 0 when the lock detector is not built.

module tb_phase_loop_filter;

`ifdef PHASE_LOOP_FILTER_LOCK_DETECT_EN
    localparam bit LK = 1'b1;
`else
    localparam bit LK = 1'b0;
`endif

    logic               CLK = 1'b0;
    logic               RESET_N;
    logic               CE;
    logic signed [13:0] PHASE_IN;
    logic               PHASE_VALID;
    logic [31:0]        FREQ_BASE;
    logic               CLEAR;
    logic [31:0]        FREQ_OUT;
    logic               FREQ_VALID;
    logic               LOCKED;
    logic               SATURATED;

    int n_tests = 0;
    int n_fail  = 0;

    phase_loop_filter dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .CE          (CE),
        .PHASE_IN    (PHASE_IN),
        .PHASE_VALID (PHASE_VALID),
        .FREQ_BASE   (FREQ_BASE),
        .CLEAR       (CLEAR),
        .FREQ_OUT    (FREQ_OUT),
        .FREQ_VALID  (FREQ_VALID),
        .LOCKED      (LOCKED),
        .SATURATED   (SATURATED)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lk(input logic v);
        return LK ? 32'(v) : 32'd0;
    endfunction

    // One isolated strobe; returns on the falling edge after stage B.
    task automatic pulse(input logic signed [13:0] p);
        PHASE_IN    = p;
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        @(negedge CLK);
    endtask

    task automatic sample(input string tag, input logic signed [13:0] p,
                          input logic [31:0] exp_out, input logic exp_sat);
        pulse(p);
        check({tag, "_valid"}, 32'(FREQ_VALID), 32'd1);
        check({tag, "_out"},   FREQ_OUT,        exp_out);
        check({tag, "_sat"},   32'(SATURATED),  32'(exp_sat));
    endtask

    // n strobes on consecutive cycles; returns after the last stage-A edge.
    task automatic burst(input logic signed [13:0] p, input int n);
        PHASE_IN    = p;
        PHASE_VALID = 1'b1;
        repeat (n) @(negedge CLK);
        PHASE_VALID = 1'b0;
    endtask

    task automatic do_clear;
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        RESET_N     = 1'b0;
        CE          = 1'b1;
        PHASE_IN    = '0;
        PHASE_VALID = 1'b0;
        FREQ_BASE   = '0;
        CLEAR       = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_out",   FREQ_OUT,         32'd0);
        check("rst_valid", 32'(FREQ_VALID),  32'd0);
        check("rst_lock",  32'(LOCKED),      32'd0);
        check("rst_sat",   32'(SATURATED),   32'd0);
        RESET_N = 1'b1;
        @(negedge CLK);

        // single step with latency check
        FREQ_BASE   = 32'h1000_0000;
        PHASE_IN    = 14'sd3;
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        check("step_early", 32'(FREQ_VALID), 32'd0);
        @(negedge CLK);
        check("step_valid", 32'(FREQ_VALID), 32'd1);
        check("step_out",   FREQ_OUT,        32'h1000_003C);
        check("step_sat",   32'(SATURATED),  32'd0);
        @(negedge CLK);
        check("step_pulse_end", 32'(FREQ_VALID), 32'd0);

        // CLEAR leaves FREQ_OUT untouched
        do_clear;
        check("clr_hold_out", FREQ_OUT, 32'h1000_003C);

        // negative accumulation
        sample("neg1", -14'sd5, 32'h0FFF_FF9C, 1'b0);
        sample("neg2", -14'sd5, 32'h0FFF_FF88, 1'b0);

        // back-to-back strobes
        do_clear;
        PHASE_IN    = 14'sd1;
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_IN = 14'sd2;
        @(negedge CLK);
        check("b2b1_valid", 32'(FREQ_VALID), 32'd1);
        check("b2b1_out",   FREQ_OUT,        32'h1000_0014);
        PHASE_IN = 14'sd3;
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        check("b2b2_valid", 32'(FREQ_VALID), 32'd1);
        check("b2b2_out",   FREQ_OUT,        32'h1000_002C);
        @(negedge CLK);
        check("b2b3_valid", 32'(FREQ_VALID), 32'd1);
        check("b2b3_out",   FREQ_OUT,        32'h1000_0048);
        @(negedge CLK);
        check("b2b_end", 32'(FREQ_VALID), 32'd0);

        // clock enable: pipeline stalls, strobe ignored, valid self-clears
        do_clear;
        PHASE_IN    = 14'sd4;
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_IN = 14'sd7;
        CE       = 1'b0;
        @(negedge CLK);
        check("ce_stall_valid", 32'(FREQ_VALID), 32'd0);
        check("ce_stall_out",   FREQ_OUT,        32'h1000_0048);
        PHASE_VALID = 1'b0;
        CE          = 1'b1;
        @(negedge CLK);
        check("ce_resume_valid", 32'(FREQ_VALID), 32'd1);
        check("ce_resume_out",   FREQ_OUT,        32'h1000_0050);
        CE = 1'b0;
        @(negedge CLK);
        check("ce_valid_clears", 32'(FREQ_VALID), 32'd0);
        CE = 1'b1;
        @(negedge CLK);
        check("ce_no_extra", 32'(FREQ_VALID), 32'd0);
        sample("ce_probe", 14'sd0, 32'h1000_0010, 1'b0);

        // lock detector
        do_clear;
        burst(14'sd2, 63);
        check("lock_63", 32'(LOCKED), 32'd0);
        burst(14'sd2, 1);
        check("lock_64", 32'(LOCKED), lk(1'b1));
        for (int i = 0; i < 3; i++) begin
            pulse(14'sd100);
            check("loss_hold", 32'(LOCKED), lk(1'b1));
        end
        pulse(14'sd100);
        check("loss_4", 32'(LOCKED), 32'd0);
        pulse(14'sd2);
        pulse(14'h2000);
        burst(14'sd2, 63);
        check("min_not_in", 32'(LOCKED), 32'd0);
        burst(14'sd2, 1);
        check("relock", 32'(LOCKED), lk(1'b1));
        for (int i = 0; i < 3; i++) begin
            pulse(14'sd9);
            check("thr9_hold", 32'(LOCKED), lk(1'b1));
        end
        pulse(14'sd8);
        check("thr8_in", 32'(LOCKED), lk(1'b1));
        for (int i = 0; i < 3; i++) begin
            pulse(14'sd9);
            check("bad_reset_hold", 32'(LOCKED), lk(1'b1));
        end
        pulse(-14'sd9);
        check("thr_neg9_loss", 32'(LOCKED), 32'd0);
        burst(14'sd2, 64);
        check("relock2", 32'(LOCKED), lk(1'b1));
        @(negedge CLK);

        // CLEAR colliding with PHASE_VALID
        CLEAR       = 1'b1;
        PHASE_IN    = 14'sd50;
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        CLEAR       = 1'b0;
        PHASE_VALID = 1'b0;
        check("coll_valid0", 32'(FREQ_VALID), 32'd0);
        check("coll_lock",   32'(LOCKED),     32'd0);
        @(negedge CLK);
        check("coll_valid1", 32'(FREQ_VALID), 32'd0);
        sample("coll_probe", 14'sd0, 32'h1000_0000, 1'b0);

        // CLEAR cancels a pending stage B
        PHASE_IN    = 14'sd5;
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        CLEAR       = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        check("cancel_valid", 32'(FREQ_VALID), 32'd0);
        check("cancel_out",   FREQ_OUT,        32'h1000_0000);
        @(negedge CLK);
        check("cancel_valid2", 32'(FREQ_VALID), 32'd0);
        sample("cancel_probe", 14'sd0, 32'h1000_0000, 1'b0);

        // saturation
        do_clear;
        FREQ_BASE = 32'h0;
        sample("lowclamp", 14'h2000, 32'h0, 1'b1);
        do_clear;
        FREQ_BASE = 32'hFFFF_FFF0;
        sample("hiclamp", 14'sd10, 32'hFFFF_FFFF, 1'b1);
        do_clear;
        FREQ_BASE = 32'h0;
        burst(14'sd8191, 600);
        @(negedge CLK);
        check("intmax_valid", 32'(FREQ_VALID), 32'd1);
        check("intmax_out",   FREQ_OUT,        32'h0101_FFF0);
        check("intmax_sat",   32'(SATURATED),  32'd1);
        sample("intlim",    14'sd0,  32'h0100_0000, 1'b0);
        sample("intlim_dn", -14'sd1, 32'h00FF_FFEC, 1'b0);
        sample("resat",     14'sd8191, 32'h0101_FFF0, 1'b1);

        // reset in the middle of the pipeline
        FREQ_BASE   = 32'h1000_0000;
        PHASE_IN    = 14'sd3;
        PHASE_VALID = 1'b1;
        @(negedge CLK);
        PHASE_VALID = 1'b0;
        #2;
        RESET_N = 1'b0;
        #1;
        check("arst_out",   FREQ_OUT,        32'd0);
        check("arst_valid", 32'(FREQ_VALID), 32'd0);
        check("arst_lock",  32'(LOCKED),     32'd0);
        check("arst_sat",   32'(SATURATED),  32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("arst_no_valid", 32'(FREQ_VALID), 32'd0);
        end
        sample("arst_probe", 14'sd0, 32'h1000_0000, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
